// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared widths and bus-FSM state encoding for the memory-access stage.
package mem_access_pkg;

   localparam int ADDR  = 32;   // pc / data-memory address width
   localparam int W_OPR = 32;   // operand / result / data width
   localparam int W_RD  = 5;    // destination register index width

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } bus_state_e;

endpackage

// File: rtl/mem_access_bus_fsm.sv
// mem_access_bus_fsm
//   Data-memory side of the stage: request latches, timeout counter and the
//   completion buffer used when writeback is stalled at ack time.
//
//   state | meaning
//   IDLE  | no access outstanding, stage may accept
//   BUSY  | dmem_req_o high, waiting for ack or timeout
//   DRAIN | access finished, result parked until output register is free
//
// Ports
//   i_start, i_start_we/addr/wdata : launch an access (only sampled in IDLE)
//   i_out_free                     : output register can be loaded this cycle
//   i_dmem_ack, i_dmem_rdata       : memory completion
//   o_busy                         : state != IDLE
//   o_done_pulse                   : load output register now
//   o_timeout_pulse                : access aborted this cycle
//   o_done_wb, o_done_data         : write-enable qualifier / data for writeback
//   o_dmem_req/we/addr/wdata       : memory request port
module mem_access_bus_fsm
   import mem_access_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_start_we,
   input  logic [ADDR-1:0]  i_start_addr,
   input  logic [W_OPR-1:0] i_start_wdata,
   input  logic             i_out_free,
   input  logic             i_dmem_ack,
   input  logic [W_OPR-1:0] i_dmem_rdata,
   output logic             o_busy,
   output logic             o_done_pulse,
   output logic             o_timeout_pulse,
   output logic             o_done_wb,
   output logic [W_OPR-1:0] o_done_data,
   output logic             o_dmem_req,
   output logic             o_dmem_we,
   output logic [ADDR-1:0]  o_dmem_addr,
   output logic [W_OPR-1:0] o_dmem_wdata
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   bus_state_e       r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic             r_we;
   logic [ADDR-1:0]  r_addr;
   logic [W_OPR-1:0] r_wdata;
   logic [W_OPR-1:0] r_buf_data;
   logic             r_buf_wb;
   logic             w_cnt_hit;
   logic             w_done;
   logic             w_timeout;

   // Last permitted BUSY cycle; an ack arriving here still wins.
   assign w_cnt_hit = (r_cnt == CW'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) w_state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            if (i_dmem_ack || w_cnt_hit) begin
               w_timeout = !i_dmem_ack;
               if (i_out_free) begin
                  w_done      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (i_out_free) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_buf_data <= '0;
         r_buf_wb   <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         if (i_start) begin
            r_cnt   <= '0;
            r_we    <= i_start_we;
            r_addr  <= i_start_addr;
            r_wdata <= i_start_wdata;
         end
      end else if (r_state == ST_BUSY) begin
         r_cnt <= r_cnt + 1'b1;
         // Buffer is written on every completion; it is only read from DRAIN.
         if (i_dmem_ack) begin
            r_buf_data <= i_dmem_rdata;
            r_buf_wb   <= !r_we;
         end else if (w_cnt_hit) begin
            r_buf_data <= '0;
            r_buf_wb   <= 1'b0;
         end
      end
   end

   assign o_busy          = (r_state != ST_IDLE);
   assign o_done_pulse    = w_done;
   assign o_timeout_pulse = w_timeout;
   assign o_done_wb       = (r_state == ST_DRAIN) ? r_buf_wb : (i_dmem_ack & !r_we);
   assign o_done_data     = (r_state == ST_DRAIN) ? r_buf_data : i_dmem_rdata;
   assign o_dmem_req      = (r_state == ST_BUSY);
   assign o_dmem_we       = r_we;
   assign o_dmem_addr     = r_addr;
   assign o_dmem_wdata    = r_wdata;

endmodule

// File: rtl/mem_access.sv
// mem_access
//   Memory-access pipeline stage between execute and writeback. ALU results
//   pass through in one cycle; loads/stores go out on the req/ack port.
//
// Ports
//   clk, reset (async, active low)
//   v_i/stall_o, pc_i, result_i, wb_r_i, wb_i, mem_read_i, mem_write_i,
//   mem_data_i                                  : from execute
//   dmem_req_o/we_o/addr_o/wdata_o, dmem_ack_i, dmem_rdata_i : data memory
//   v_o/stall_i, pc_o, wb_r_o, wb_o, wb_data_o  : to writeback
//   err_o                                       : sticky bus-timeout flag
module mem_access
   import mem_access_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             v_i,
   output logic             stall_o,
   input  logic [ADDR-1:0]  pc_i,
   input  logic [W_OPR-1:0] result_i,
   input  logic [W_RD-1:0]  wb_r_i,
   input  logic             wb_i,
   input  logic             mem_read_i,
   input  logic             mem_write_i,
   input  logic [W_OPR-1:0] mem_data_i,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   output logic [ADDR-1:0]  dmem_addr_o,
   output logic [W_OPR-1:0] dmem_wdata_o,
   input  logic             dmem_ack_i,
   input  logic [W_OPR-1:0] dmem_rdata_i,
   output logic             v_o,
   input  logic             stall_i,
   output logic [ADDR-1:0]  pc_o,
   output logic [W_RD-1:0]  wb_r_o,
   output logic             wb_o,
   output logic [W_OPR-1:0] wb_data_o,
   output logic             err_o
);

   logic             r_v, r_wb, r_err;
   logic [ADDR-1:0]  r_pc;
   logic [W_RD-1:0]  r_wb_r;
   logic [W_OPR-1:0] r_data;
   logic [ADDR-1:0]  r_pc_l;
   logic [W_RD-1:0]  r_wb_r_l;
   logic             r_wb_l;

   logic             w_out_free, w_accept, w_is_mem, w_start;
   logic             w_busy, w_done, w_timeout, w_done_wb;
   logic [W_OPR-1:0] w_done_data;

   assign w_out_free = !r_v | !stall_i;
   assign stall_o    = w_busy | (r_v & stall_i);
   assign w_accept   = v_i & !stall_o;
   assign w_is_mem   = mem_read_i | mem_write_i;
   assign w_start    = w_accept & w_is_mem;

   // mem_write_i alone decides direction, so read+write behaves as a store.
   mem_access_bus_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_bus (
      .clk             (clk),
      .reset           (reset),
      .i_start         (w_start),
      .i_start_we      (mem_write_i),
      .i_start_addr    (result_i[ADDR-1:0]),
      .i_start_wdata   (mem_data_i),
      .i_out_free      (w_out_free),
      .i_dmem_ack      (dmem_ack_i),
      .i_dmem_rdata    (dmem_rdata_i),
      .o_busy          (w_busy),
      .o_done_pulse    (w_done),
      .o_timeout_pulse (w_timeout),
      .o_done_wb       (w_done_wb),
      .o_done_data     (w_done_data),
      .o_dmem_req      (dmem_req_o),
      .o_dmem_we       (dmem_we_o),
      .o_dmem_addr     (dmem_addr_o),
      .o_dmem_wdata    (dmem_wdata_o)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc_l   <= '0;
         r_wb_r_l <= '0;
         r_wb_l   <= 1'b0;
      end else if (w_start) begin
         r_pc_l   <= pc_i;
         r_wb_r_l <= wb_r_i;
         r_wb_l   <= wb_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_v    <= 1'b0;
         r_pc   <= '0;
         r_wb_r <= '0;
         r_wb   <= 1'b0;
         r_data <= '0;
      end else if (w_out_free) begin
         if (w_done) begin
            r_v    <= 1'b1;
            r_pc   <= r_pc_l;
            r_wb_r <= r_wb_r_l;
            r_wb   <= r_wb_l & w_done_wb;
            r_data <= w_done_wb ? w_done_data : '0;
         end else if (w_accept && !w_is_mem) begin
            r_v    <= 1'b1;
            r_pc   <= pc_i;
            r_wb_r <= wb_r_i;
            r_wb   <= wb_i;
            r_data <= result_i;
         end else begin
            r_v    <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
   end

   assign v_o       = r_v;
   assign pc_o      = r_pc;
   assign wb_r_o    = r_wb_r;
   assign wb_o      = r_wb;
   assign wb_data_o = r_data;
   assign err_o     = r_err;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
//   Randomized bench with a scoreboard: accepted instructions push expected
//   writeback records and expected memory requests; a memory responder and a
//   writeback monitor pop and compare.
module tb_mem_access;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        v_i, stall_o, wb_i, mem_read_i, mem_write_i;
   logic [31:0] pc_i, result_i, mem_data_i;
   logic [4:0]  wb_r_i;
   logic        dmem_req_o, dmem_we_o, dmem_ack_i;
   logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
   logic        v_o, stall_i, wb_o, err_o;
   logic [31:0] pc_o, wb_data_o;
   logic [4:0]  wb_r_o;

   mem_access #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .v_i(v_i), .stall_o(stall_o), .pc_i(pc_i),
      .result_i(result_i), .wb_r_i(wb_r_i), .wb_i(wb_i), .mem_read_i(mem_read_i),
      .mem_write_i(mem_write_i), .mem_data_i(mem_data_i), .dmem_req_o(dmem_req_o),
      .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .v_o(v_o), .stall_i(stall_i),
      .pc_o(pc_o), .wb_r_o(wb_r_o), .wb_o(wb_o), .wb_data_o(wb_data_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  wbr;
      logic        wb;
      logic [31:0] data;
      logic        err;
      int          exp_cyc;
   } out_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          d;
   } req_t;

   out_t        exp_q[$];
   req_t        req_q[$];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] dev_mem [logic [31:0]];
   logic        exp_err = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hC3C3_0000);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] dev_read(input logic [31:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
   endfunction

   task automatic idle(input int n, input int stall_pct);
      repeat (n) begin
         @(posedge clk); #1;
         v_i         = 1'b0;
         stall_i     = ($urandom_range(0, 99) < stall_pct);
         pc_i        = $urandom;
         result_i    = $urandom;
         mem_data_i  = $urandom;
         wb_r_i      = 5'($urandom);
         wb_i        = 1'($urandom);
         mem_read_i  = 1'($urandom);
         mem_write_i = 1'($urandom);
      end
   endtask

   // kind: 0 alu, 1 load, 2 store, 3 read+write (store). d: memory delay in
   // cycles before the ack cycle; d >= T means the access times out.
   task automatic issue(input int kind, input logic [31:0] res, input logic [31:0] sdata,
                        input logic [4:0] wbr, input logic wb, input int d,
                        input int stall_pct, input bit timed);
      logic [31:0] pc;
      bit          acc;
      bit          tmo;
      int          guard;
      out_t        o;
      req_t        r;
      pc    = $urandom;
      acc   = 0;
      guard = 0;
      while (!acc) begin
         @(posedge clk); #1;
         stall_i     = ($urandom_range(0, 99) < stall_pct);
         v_i         = 1'b1;
         pc_i        = pc;
         result_i    = res;
         mem_data_i  = sdata;
         wb_r_i      = wbr;
         wb_i        = wb;
         mem_read_i  = (kind == 1 || kind == 3);
         mem_write_i = (kind == 2 || kind == 3);
         @(negedge clk);
         if (!stall_o) acc = 1;
         else if (++guard > 300) begin
            check("accept_timeout", 32'(acc), 32'd1);
            return;
         end
      end
      tmo = (kind != 0) && (d >= T);
      if (kind != 0) begin
         r.we = (kind >= 2); r.addr = res; r.wdata = sdata; r.d = d;
         req_q.push_back(r);
      end
      if (tmo) exp_err = 1'b1;
      o.pc   = pc;
      o.wbr  = wbr;
      o.wb   = (kind <= 1) && !tmo && wb;
      o.data = (kind == 0) ? res : ((kind == 1 && !tmo) ? ref_read(res) : 32'h0);
      o.err  = exp_err;
      o.exp_cyc = !timed ? -1 :
                  (cyc + ((kind == 0) ? 1 : (tmo ? 1 + T : 2 + d)));
      if (kind >= 2 && !tmo) ref_mem[res] = sdata;
      exp_q.push_back(o);
   endtask

   // Memory device
   initial begin : responder
      bit   active;
      int   cnt;
      req_t cur;
      active = 0;
      cnt    = 0;
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = '0;
      forever begin
         @(negedge clk);
         dmem_ack_i   = 1'b0;
         dmem_rdata_i = $urandom;
         if (!reset) begin
            active = 0;
         end else if (dmem_req_o) begin
            if (!active) begin
               if (req_q.size() == 0) begin
                  check("unexpected_req", 32'(dmem_req_o), 32'd0);
                  cur.we = dmem_we_o; cur.addr = dmem_addr_o; cur.wdata = dmem_wdata_o; cur.d = 0;
               end else begin
                  cur = req_q.pop_front();
               end
               active = 1;
               cnt    = 0;
            end
            check("req_we", 32'(dmem_we_o), 32'(cur.we));
            check("req_addr", dmem_addr_o, cur.addr);
            if (cur.we) check("req_wdata", dmem_wdata_o, cur.wdata);
            check("stall_o_busy", 32'(stall_o), 32'd1);
            if (cnt == cur.d) begin
               dmem_ack_i = 1'b1;
               if (cur.we) dev_mem[cur.addr] = cur.wdata;
               else        dmem_rdata_i = dev_read(cur.addr);
               active = 0;
            end
            cnt++;
         end else if (active) begin
            check("timeout_req_cycles", 32'(cnt), 32'(T));
            active = 0;
         end
      end
   end

   // Writeback monitor
   initial begin : monitor
      out_t e;
      forever begin
         @(negedge clk);
         if (reset && v_o && !stall_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_v_o", 32'(v_o), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("pc_o", pc_o, e.pc);
               check("wb_r_o", 32'(wb_r_o), 32'(e.wbr));
               check("wb_o", 32'(wb_o), 32'(e.wb));
               check("wb_data_o", wb_data_o, e.data);
               check("err_o", 32'(err_o), 32'(e.err));
               if (e.exp_cyc >= 0) check("latency", 32'(cyc), 32'(e.exp_cyc));
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || req_q.size() != 0) && g < 500) begin
         idle(1, 0);
         g++;
      end
      idle(2, 0);
      check("drain_empty", 32'(exp_q.size() + req_q.size()), 32'd0);
   endtask

   initial begin : main
      reset = 1'b0;
      v_i = 0; stall_i = 0; pc_i = 0; result_i = 0; mem_data_i = 0;
      wb_r_i = 0; wb_i = 0; mem_read_i = 0; mem_write_i = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_v_o", 32'(v_o), 0);
      check("rst_wb_o", 32'(wb_o), 0);
      check("rst_req", 32'(dmem_req_o), 0);
      check("rst_we", 32'(dmem_we_o), 0);
      check("rst_err", 32'(err_o), 0);
      check("rst_pc_o", pc_o, 0);
      check("rst_wb_data", wb_data_o, 0);
      check("rst_addr", dmem_addr_o, 0);
      check("rst_stall_o", 32'(stall_o), 0);
      @(negedge clk);
      reset = 1'b1;

      // Directed, no downstream stall, latency checked
      issue(0, 32'h1234, 32'h0, 5'd3, 1'b1, 0, 0, 1);
      issue(1, 32'h100, 32'h0, 5'd7, 1'b1, 2, 0, 1);
      issue(2, 32'h40, 32'h55, 5'd9, 1'b1, 1, 0, 1);
      issue(1, 32'h88, 32'h0, 5'd4, 1'b1, T - 1, 0, 1);
      issue(3, 32'h44, 32'h77, 5'd5, 1'b1, 0, 0, 1);
      issue(1, 32'h40, 32'h0, 5'd6, 1'b1, 0, 0, 1);
      issue(0, 32'hABCD, 32'h0, 5'd1, 1'b0, 0, 0, 1);
      drain();
      check("err_before_timeout", 32'(err_o), 0);
      issue(1, 32'h80, 32'h0, 5'd2, 1'b1, T + 5, 0, 1);
      issue(0, 32'h5555, 32'h0, 5'd8, 1'b1, 0, 0, 1);
      drain();
      check("err_sticky", 32'(err_o), 1);

      // Randomized with downstream backpressure
      for (int i = 0; i < 300; i++) begin
         issue($urandom_range(0, 3), 32'h100 + {$urandom_range(0, 15), 2'b00}, $urandom,
               5'($urandom), 1'($urandom), $urandom_range(0, T + 1), 40, 0);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 40);
      end
      drain();

      // Asynchronous reset in the middle of an access
      req_q.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0, d: 100});
      @(posedge clk); #1;
      stall_i = 0; v_i = 1; mem_read_i = 1; mem_write_i = 0;
      result_i = 32'h104; mem_data_i = 0; pc_i = 32'h2000; wb_r_i = 5'd1; wb_i = 1;
      @(negedge clk);
      check("rst_test_accept", 32'(stall_o), 0);
      @(posedge clk); #1;
      v_i = 0;
      @(posedge clk); #3;
      check("pre_reset_req", 32'(dmem_req_o), 1);
      reset = 1'b0;
      #1;
      check("async_req", 32'(dmem_req_o), 0);
      check("async_v_o", 32'(v_o), 0);
      check("async_stall_o", 32'(stall_o), 0);
      check("async_err", 32'(err_o), 0);
      exp_q.delete();
      req_q.delete();
      @(negedge clk);
      reset = 1'b1;
      idle(2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
